// File: rtl/usb_rx_packet_decoder_pkg.sv
// Shared USB packet definitions: PID encoding, packet-type masks, field widths,
// receive-decoder error codes and CRC5/CRC16 constants.
package usb_rx_packet_decoder_pkg;

  typedef enum logic [3:0] {
    PID_RESERVED = 4'b0000,
    PID_OUT      = 4'b0001,
    PID_ACK      = 4'b0010,
    PID_DATA0    = 4'b0011,
    PID_PING     = 4'b0100,
    PID_SOF      = 4'b0101,
    PID_NYET     = 4'b0110,
    PID_DATA2    = 4'b0111,
    PID_SPLIT    = 4'b1000,
    PID_IN       = 4'b1001,
    PID_NAK      = 4'b1010,
    PID_DATA1    = 4'b1011,
    PID_PRE      = 4'b1100,
    PID_SETUP    = 4'b1101,
    PID_STALL    = 4'b1110,
    PID_MDATA    = 4'b1111
  } UsbPid;

  // Packet group lives in PID bits [1:0].
  localparam logic [1:0] PID_TYPE_SPECIAL   = 2'b00;
  localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
  localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA      = 2'b11;

  localparam int USB_ADDR_W  = 7;
  localparam int USB_ENDP_W  = 4;
  localparam int USB_FRAME_W = 11;

  typedef enum logic [2:0] {
    ERR_NONE            = 3'd0,
    ERR_PID_CHECK       = 3'd1,
    ERR_UNSUPPORTED_PID = 3'd2,
    ERR_LENGTH          = 3'd3,
    ERR_CRC             = 3'd4,
    ERR_PHY             = 3'd5
  } RxDecodeErr;

  localparam int          CRC5_W          = 5;
  localparam logic [4:0]  CRC5_POLY       = 5'b00101;
  localparam logic [4:0]  CRC5_PRESET     = 5'b11111;
  localparam logic [4:0]  CRC5_RESIDUAL   = 5'b01100;
  localparam int          CRC16_W         = 16;
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_PRESET    = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;

endpackage

// File: rtl/usb_rx_packet_decoder_if.sv
// Byte stream from the deserializer plus the decoded event bus to the protocol engine.
interface usb_rx_packet_decoder_if;
  import usb_rx_packet_decoder_pkg::*;

  logic                   rx_start;
  logic                   rx_valid;
  logic [7:0]             rx_byte;
  logic                   rx_eop;
  logic                   rx_phy_err;

  UsbPid                  pid;
  logic                   token_valid;
  logic [USB_ADDR_W-1:0]  dev_addr;
  logic [USB_ENDP_W-1:0]  endpt;
  logic                   sof_valid;
  logic [USB_FRAME_W-1:0] frame_num;
  logic                   hs_valid;
  logic                   data_start;
  logic                   data_valid;
  logic [7:0]             data_byte;
  logic                   data_end;
  logic                   data_ok;
  logic                   err_valid;
  RxDecodeErr             err_code;

  modport master (
    output rx_start, rx_valid, rx_byte, rx_eop, rx_phy_err,
    input  pid, token_valid, dev_addr, endpt, sof_valid, frame_num, hs_valid,
           data_start, data_valid, data_byte, data_end, data_ok, err_valid, err_code
  );

  modport slave (
    input  rx_start, rx_valid, rx_byte, rx_eop, rx_phy_err,
    output pid, token_valid, dev_addr, endpt, sof_valid, frame_num, hs_valid,
           data_start, data_valid, data_byte, data_end, data_ok, err_valid, err_code
  );

endinterface

// File: rtl/usb_crc_serial.sv
// Byte-parallel USB CRC register: folds 8 bits per enabled cycle, LSb first.
module usb_crc_serial #(
  parameter int               WIDTH  = 5,
  parameter logic [WIDTH-1:0] POLY   = '0,
  parameter logic [WIDTH-1:0] PRESET = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] crc
);

  function automatic logic [WIDTH-1:0] nextCrc(input logic [WIDTH-1:0] cur, input logic [7:0] d);
    logic [WIDTH-1:0] r;
    r = cur;
    for (int i = 0; i < 8; i++) begin
      if (r[WIDTH-1] ^ d[i]) r = {r[WIDTH-2:0], 1'b0} ^ POLY;
      else                   r = {r[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     crc <= PRESET;
    else if (clear) crc <= PRESET;
    else if (en)    crc <= nextCrc(crc, data);
  end

endmodule

// File: rtl/usb_rx_packet_decoder.sv
// USB receive packet decoder: PID check, token/SOF field extraction, data CRC16 strip.
// Optional feature macro USB_RX_CRC_CHECK_EN builds the CRC5/CRC16 checkers.
module usb_rx_packet_decoder
  import usb_rx_packet_decoder_pkg::*;
(
  input logic                    clk12,
  input logic                    rst_n,
  usb_rx_packet_decoder_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PID      = 3'd1;
  localparam logic [2:0] S_TOK1     = 3'd2;
  localparam logic [2:0] S_TOK2     = 3'd3;
  localparam logic [2:0] S_WAIT_EOP = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;
  localparam logic [2:0] S_DISCARD  = 3'd6;

  logic [2:0] state;
  RxDecodeErr errLatch;
  RxDecodeErr abortCode;
  RxDecodeErr phyCode;
  logic [7:0] tokByte0;
  logic [7:0] bufOld;
  logic [7:0] bufNew;
  logic [1:0] bufCount;
  logic       pidOk;
  UsbPid      rxPid;
  logic       crc5Good;
  logic       crc16Good;

  assign rxPid     = UsbPid'(bus.rx_byte[3:0]);
  assign pidOk     = (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]);
  assign abortCode = (errLatch == ERR_NONE) ? ERR_LENGTH : errLatch;
  assign phyCode   = (errLatch == ERR_NONE) ? ERR_PHY : errLatch;

`ifdef USB_RX_CRC_CHECK_EN
  logic [CRC5_W-1:0]  crc5;
  logic [CRC16_W-1:0] crc16;

  usb_crc_serial #(.WIDTH(CRC5_W), .POLY(CRC5_POLY), .PRESET(CRC5_PRESET)) u_crc5 (
    .clk(clk12), .rst_n(rst_n), .clear(bus.rx_start),
    .en(bus.rx_valid && (state == S_TOK1 || state == S_TOK2)),
    .data(bus.rx_byte), .crc(crc5)
  );

  usb_crc_serial #(.WIDTH(CRC16_W), .POLY(CRC16_POLY), .PRESET(CRC16_PRESET)) u_crc16 (
    .clk(clk12), .rst_n(rst_n), .clear(bus.rx_start),
    .en(bus.rx_valid && state == S_DATA),
    .data(bus.rx_byte), .crc(crc16)
  );

  assign crc5Good  = (crc5 == CRC5_RESIDUAL);
  assign crc16Good = (crc16 == CRC16_RESIDUAL);
`else
  assign crc5Good  = 1'b1;
  assign crc16Good = 1'b1;
`endif

  always_ff @(posedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      errLatch         <= ERR_NONE;
      tokByte0         <= '0;
      // NOTE: the two-byte delay line is reset as well so data_byte never shows stale payload.
      bufOld           <= '0;
      bufNew           <= '0;
      bufCount         <= '0;
      bus.pid          <= PID_RESERVED;
      bus.token_valid  <= 1'b0;
      bus.dev_addr     <= '0;
      bus.endpt        <= '0;
      bus.sof_valid    <= 1'b0;
      bus.frame_num    <= '0;
      bus.hs_valid     <= 1'b0;
      bus.data_start   <= 1'b0;
      bus.data_valid   <= 1'b0;
      bus.data_byte    <= '0;
      bus.data_end     <= 1'b0;
      bus.data_ok      <= 1'b0;
      bus.err_valid    <= 1'b0;
      bus.err_code     <= ERR_NONE;
    end else begin
      bus.token_valid <= 1'b0;
      bus.sof_valid   <= 1'b0;
      bus.hs_valid    <= 1'b0;
      bus.data_start  <= 1'b0;
      bus.data_valid  <= 1'b0;
      bus.data_end    <= 1'b0;
      bus.data_ok     <= 1'b0;
      bus.err_valid   <= 1'b0;

      if (bus.rx_start) begin
        // A new packet cuts short whatever was in flight.
        if (state != S_IDLE) begin
          bus.err_valid <= 1'b1;
          bus.err_code  <= abortCode;
          if (state == S_DATA) bus.data_end <= 1'b1;
        end
        errLatch <= ERR_NONE;
        state    <= S_PID;
      end else if (bus.rx_phy_err && state != S_IDLE) begin
        if (bus.rx_eop) begin
          bus.err_valid <= 1'b1;
          bus.err_code  <= phyCode;
          state         <= S_IDLE;
        end else begin
          errLatch <= phyCode;
          state    <= S_DISCARD;
        end
      end else begin
        case (state)
          S_PID: begin
            if (bus.rx_eop) begin
              bus.err_valid <= 1'b1;
              bus.err_code  <= ERR_LENGTH;
              state         <= S_IDLE;
            end else if (bus.rx_valid) begin
              if (!pidOk) begin
                errLatch <= ERR_PID_CHECK;
                state    <= S_DISCARD;
              end else begin
                case (rxPid[1:0])
                  PID_TYPE_TOKEN: begin
                    bus.pid <= rxPid;
                    state   <= S_TOK1;
                  end
                  PID_TYPE_HANDSHAKE: begin
                    bus.pid <= rxPid;
                    state   <= S_WAIT_EOP;
                  end
                  PID_TYPE_DATA: begin
                    if (rxPid == PID_DATA0 || rxPid == PID_DATA1) begin
                      bus.pid        <= rxPid;
                      bus.data_start <= 1'b1;
                      bufCount       <= '0;
                      state          <= S_DATA;
                    end else begin
                      errLatch <= ERR_UNSUPPORTED_PID;
                      state    <= S_DISCARD;
                    end
                  end
                  default: begin
                    errLatch <= ERR_UNSUPPORTED_PID;
                    state    <= S_DISCARD;
                  end
                endcase
              end
            end
          end
          S_TOK1, S_TOK2: begin
            if (bus.rx_eop) begin
              bus.err_valid <= 1'b1;
              bus.err_code  <= ERR_LENGTH;
              state         <= S_IDLE;
            end else if (bus.rx_valid && state == S_TOK1) begin
              tokByte0 <= bus.rx_byte;
              state    <= S_TOK2;
            end else if (bus.rx_valid) begin
              if (bus.pid == PID_SOF) begin
                bus.frame_num <= {bus.rx_byte[2:0], tokByte0};
              end else begin
                bus.dev_addr <= tokByte0[USB_ADDR_W-1:0];
                bus.endpt    <= {bus.rx_byte[2:0], tokByte0[7]};
              end
              state <= S_WAIT_EOP;
            end
          end
          S_WAIT_EOP: begin
            if (bus.rx_valid) begin
              errLatch <= ERR_LENGTH;
              state    <= S_DISCARD;
            end else if (bus.rx_eop) begin
              if (bus.pid[1:0] == PID_TYPE_HANDSHAKE) bus.hs_valid <= 1'b1;
              else if (!crc5Good) begin
                bus.err_valid <= 1'b1;
                bus.err_code  <= ERR_CRC;
              end else if (bus.pid == PID_SOF) bus.sof_valid <= 1'b1;
              else bus.token_valid <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_DATA: begin
            // Bytes leave the delay line only when pushed out, so the CRC16 trailer stays behind.
            if (bus.rx_valid) begin
              if (bufCount == 2'd2) begin
                bus.data_valid <= 1'b1;
                bus.data_byte  <= bufOld;
              end else begin
                bufCount <= bufCount + 2'd1;
              end
              bufOld <= bufNew;
              bufNew <= bus.rx_byte;
            end else if (bus.rx_eop) begin
              bus.data_end <= 1'b1;
              if (bufCount != 2'd2) begin
                bus.err_valid <= 1'b1;
                bus.err_code  <= ERR_LENGTH;
              end else if (!crc16Good) begin
                bus.err_valid <= 1'b1;
                bus.err_code  <= ERR_CRC;
              end else begin
                bus.data_ok <= 1'b1;
              end
              state <= S_IDLE;
            end
          end
          S_DISCARD: begin
            if (bus.rx_eop) begin
              bus.err_valid <= 1'b1;
              bus.err_code  <= errLatch;
              state         <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Scoreboard bench for usb_rx_packet_decoder: directed packets push expected events,
// a negedge monitor pops and compares every event the decoder emits.
module tb_usb_rx_packet_decoder;
  import usb_rx_packet_decoder_pkg::*;

  localparam logic [3:0] EV_TOKEN  = 4'd1;
  localparam logic [3:0] EV_SOF    = 4'd2;
  localparam logic [3:0] EV_HS     = 4'd3;
  localparam logic [3:0] EV_DSTART = 4'd4;
  localparam logic [3:0] EV_DBYTE  = 4'd5;
  localparam logic [3:0] EV_DEND   = 4'd6;
  localparam logic [3:0] EV_ERR    = 4'd7;

  typedef struct packed {
    logic [3:0]  kind;
    logic [3:0]  pid;
    logic [10:0] f1;
    logic [7:0]  f2;
  } Evt;

  logic clk12 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk12 = ~clk12;

  usb_rx_packet_decoder_if bus();
  usb_rx_packet_decoder dut (.clk12(clk12), .rst_n(rst_n), .bus(bus));

  Evt         expQ[$];
  logic [7:0] pktBytes[$];
  int         nChecks = 0;
  int         nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic Evt mk(input logic [3:0] k, input logic [3:0] p,
                            input logic [10:0] a, input logic [7:0] b);
    Evt e;
    e.kind = k; e.pid = p; e.f1 = a; e.f2 = b;
    return e;
  endfunction

  task automatic want(input logic [3:0] k, input logic [3:0] p,
                      input logic [10:0] a, input logic [7:0] b);
    expQ.push_back(mk(k, p, a, b));
  endtask

  task automatic observe(input string name, input Evt act);
    if (expQ.size() == 0) check({name, " unexpected"}, 32'(act), 32'd0);
    else check(name, 32'(act), 32'(expQ.pop_front()));
  endtask

  // Monitor: data_end is compared before err_valid when both fire together.
  always @(negedge clk12) begin
    if (rst_n) begin
      if (bus.token_valid) observe("token", mk(EV_TOKEN, bus.pid, 11'(bus.dev_addr), 8'(bus.endpt)));
      if (bus.sof_valid)   observe("sof", mk(EV_SOF, bus.pid, bus.frame_num, 8'd0));
      if (bus.hs_valid)    observe("handshake", mk(EV_HS, bus.pid, 11'd0, 8'd0));
      if (bus.data_start)  observe("data_start", mk(EV_DSTART, bus.pid, 11'd0, 8'd0));
      if (bus.data_valid)  observe("data_byte", mk(EV_DBYTE, 4'd0, 11'd0, bus.data_byte));
      if (bus.data_end)    observe("data_end", mk(EV_DEND, 4'd0, 11'd0, 8'(bus.data_ok)));
      if (bus.err_valid)   observe("err", mk(EV_ERR, 4'd0, 11'd0, 8'(bus.err_code)));
    end
  end

  task automatic drive(input logic s, input logic v, input logic [7:0] b,
                       input logic e, input logic p);
    bus.rx_start = s; bus.rx_valid = v; bus.rx_byte = b; bus.rx_eop = e; bus.rx_phy_err = p;
    @(posedge clk12);
    #1;
    bus.rx_start = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
    bus.rx_eop = 1'b0; bus.rx_phy_err = 1'b0;
  endtask

  task automatic sendPacket();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    foreach (pktBytes[i]) drive(1'b0, 1'b1, pktBytes[i], 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    drive(1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  initial begin
    bus.rx_start = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
    bus.rx_eop = 1'b0; bus.rx_phy_err = 1'b0;
    #2;
    check("reset_pid", 32'(bus.pid), 32'd0);
    check("reset_pulses", 32'({bus.token_valid, bus.sof_valid, bus.hs_valid, bus.data_start,
          bus.data_valid, bus.data_end, bus.data_ok, bus.err_valid, bus.err_code}), 32'd0);
    check("reset_fields", 32'({bus.dev_addr, bus.endpt, bus.frame_num, bus.data_byte}), 32'd0);
    repeat (2) @(posedge clk12);
    #1 rst_n = 1'b1;

    // SETUP addr 0 ep 0
    want(EV_TOKEN, 4'hD, 11'd0, 8'd0);
    pktBytes = '{8'h2D, 8'h00, 8'h10};
    sendPacket();

    // Same token with an address bit flipped
`ifdef USB_RX_CRC_CHECK_EN
    want(EV_ERR, 4'd0, 11'd0, 8'd4);
`else
    want(EV_TOKEN, 4'hD, 11'd1, 8'd0);
`endif
    pktBytes = '{8'h2D, 8'h01, 8'h10};
    sendPacket();

    // DATA0 GET_DESCRIPTOR setup payload
    want(EV_DSTART, 4'h3, 11'd0, 8'd0);
    pktBytes = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
    foreach (pktBytes[i]) want(EV_DBYTE, 4'd0, 11'd0, pktBytes[i]);
    want(EV_DEND, 4'd0, 11'd0, 8'd1);
    pktBytes = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    sendPacket();

    // ACK, then bad PID complement
    want(EV_HS, 4'h2, 11'd0, 8'd0);
    pktBytes = '{8'hD2};
    sendPacket();
    want(EV_ERR, 4'd0, 11'd0, 8'd1);
    pktBytes = '{8'h2C};
    sendPacket();

    // Truncated token and over-long handshake
    want(EV_ERR, 4'd0, 11'd0, 8'd3);
    pktBytes = '{8'h2D, 8'h00};
    sendPacket();
    want(EV_ERR, 4'd0, 11'd0, 8'd3);
    pktBytes = '{8'hD2, 8'hFF};
    sendPacket();

    // SOF frame 1
    want(EV_SOF, 4'h5, 11'd1, 8'd0);
    pktBytes = '{8'hA5, 8'h01, 8'hE8};
    sendPacket();

    // Zero-length DATA1: only the CRC bytes
    want(EV_DSTART, 4'hB, 11'd0, 8'd0);
    want(EV_DEND, 4'd0, 11'd0, 8'd1);
    pktBytes = '{8'h4B, 8'h00, 8'h00};
    sendPacket();

    // DATA0 with a single byte after the PID
    want(EV_DSTART, 4'h3, 11'd0, 8'd0);
    want(EV_DEND, 4'd0, 11'd0, 8'd0);
    want(EV_ERR, 4'd0, 11'd0, 8'd3);
    pktBytes = '{8'hC3, 8'hAA};
    sendPacket();

    // Unsupported PIDs: DATA2 and PING
    want(EV_ERR, 4'd0, 11'd0, 8'd2);
    pktBytes = '{8'h87, 8'h00, 8'h00};
    sendPacket();
    want(EV_ERR, 4'd0, 11'd0, 8'd2);
    pktBytes = '{8'hB4, 8'h00, 8'h10};
    sendPacket();

    // PHY error mid-token, then PHY error after a PID check failure
    want(EV_ERR, 4'd0, 11'd0, 8'd5);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'h2D);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    sendByte(8'h00);
    sendByte(8'h10);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    want(EV_ERR, 4'd0, 11'd0, 8'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'h2C);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Token aborted by a new packet, which is an ACK
    want(EV_ERR, 4'd0, 11'd0, 8'd3);
    want(EV_HS, 4'h2, 11'd0, 8'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'h2D);
    sendByte(8'h00);
    pktBytes = '{8'hD2};
    sendPacket();

    // Data packet aborted after one forwarded byte
    want(EV_DSTART, 4'h3, 11'd0, 8'd0);
    want(EV_DBYTE, 4'd0, 11'd0, 8'h11);
    want(EV_DEND, 4'd0, 11'd0, 8'd0);
    want(EV_ERR, 4'd0, 11'd0, 8'd3);
    want(EV_HS, 4'h2, 11'd0, 8'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'hC3);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    sendPacket();

    // Reset in the middle of a data packet
    want(EV_DSTART, 4'h3, 11'd0, 8'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    sendByte(8'hC3);
    sendByte(8'h80);
    sendByte(8'h06);
    rst_n = 1'b0;
    #1;
    check("midreset_pid", 32'(bus.pid), 32'd0);
    check("midreset_pulses", 32'({bus.token_valid, bus.sof_valid, bus.hs_valid, bus.data_start,
          bus.data_valid, bus.data_end, bus.data_ok, bus.err_valid, bus.err_code}), 32'd0);
    check("midreset_fields", 32'({bus.dev_addr, bus.endpt, bus.frame_num, bus.data_byte}), 32'd0);
    @(posedge clk12);
    #1 rst_n = 1'b1;
    want(EV_HS, 4'h2, 11'd0, 8'd0);
    pktBytes = '{8'hD2};
    sendPacket();

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk12);
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
